// File: rtl/ldm_stm_seq_pkg.sv
// Shared definitions for the LDM/STM block-transfer sequencer:
// sequencer state codes, addressing-mode codes and the latched transfer mode.
package ldm_stm_seq_pkg;

    localparam logic SEQ_IDLE = 1'b0;
    localparam logic SEQ_XFER = 1'b1;

    // Addressing-mode codes on {P,U}
    localparam logic [1:0] AM_DA = 2'b00;
    localparam logic [1:0] AM_IA = 2'b01;
    localparam logic [1:0] AM_DB = 2'b10;
    localparam logic [1:0] AM_IB = 2'b11;

    typedef struct packed {
        logic p;
        logic u;
        logic ldm;
    } xfer_mode_t;

endpackage

// File: rtl/ldm_stm_seq_lowest_set16.sv
// 16-bit priority encoder: index of the lowest set bit, the mask with that bit
// cleared, and empty / at-most-one-bit flags.
module lowest_set16 (
    input  logic [15:0] mask,
    output logic [3:0]  idx,
    output logic [15:0] cleared,
    output logic        zero,
    output logic        le_one
);

    always_comb begin
        idx = 4'd0;
        for (int i = 15; i >= 0; i--) begin
            if (mask[i]) idx = 4'(i);
        end
    end

    assign cleared = mask & (mask - 16'd1);
    assign zero    = (mask == 16'd0);
    assign le_one  = (cleared == 16'd0);

endmodule

// File: rtl/ldm_stm_seq.sv
// Decode-stage LDM/STM sequencer: walks the register list one register per
// advancing cycle and supplies register number, address and write-back offsets.
module ldm_stm_seq
    import ldm_stm_seq_pkg::*;
(
    input  logic        nGCLK,
    input  logic        nRESET,
    input  logic        nWAIT,
    input  logic        ex_enbar,
    input  logic        squash,
    input  logic        ldm,
    input  logic        stm,
    input  logic [15:0] reg_list,
    input  logic        p_bit,
    input  logic        u_bit,
    output logic        seq_active,
    output logic [3:0]  cur_reg,
    output logic        first_xfer,
    output logic        finished,
    output logic [7:0]  addr_offset,
    output logic [7:0]  wb_offset,
    output logic        pc_xfer,
    output logic        empty_list
);

    logic        state_q;
    logic [15:0] remain_q;
    logic [3:0]  k_q;
    logic [4:0]  n_reg_q;
    xfer_mode_t  mode_q;

    logic        idle, instr, advance;
    logic [15:0] work, work_cleared;
    logic [3:0]  cur_idx;
    logic        work_zero, work_le_one;
    logic [4:0]  live_n, n_eff;
    logic [3:0]  k_eff;
    xfer_mode_t  mode;
    logic [7:0]  k4, n4;

    function automatic logic [4:0] popcount16(input logic [15:0] v);
        logic [4:0] sum;
        sum = 5'd0;
        for (int i = 0; i < 16; i++) sum = sum + {4'd0, v[i]};
        return sum;
    endfunction

    assign idle    = (state_q == SEQ_IDLE);
    assign instr   = ldm | stm;
    assign advance = nWAIT & ~ex_enbar & ~squash;
    assign work    = idle ? reg_list : remain_q;
    assign live_n  = popcount16(reg_list);

    lowest_set16 u_lowest (
        .mask    (work),
        .idx     (cur_idx),
        .cleared (work_cleared),
        .zero    (work_zero),
        .le_one  (work_le_one)
    );

    // An empty list behaves architecturally as a 16-word transfer for write-back
    assign k_eff = idle ? 4'd0 : k_q;
    assign n_eff = idle ? ((live_n == 5'd0) ? 5'd16 : live_n) : n_reg_q;
    assign mode  = idle ? '{p: p_bit, u: u_bit, ldm: ldm} : mode_q;
    assign k4    = {2'b00, k_eff, 2'b00};
    assign n4    = {1'b0, n_eff, 2'b00};

    always_comb begin
        addr_offset = 8'd0;
        wb_offset   = 8'd0;
        if (!idle || instr) begin
            unique case ({mode.p, mode.u})
                AM_IA: addr_offset = k4;
                AM_IB: addr_offset = k4 + 8'd4;
                AM_DA: addr_offset = k4 - n4 + 8'd4;
                AM_DB: addr_offset = k4 - n4;
            endcase
            wb_offset = mode.u ? n4 : (8'd0 - n4);
        end
    end

    assign seq_active = ~idle;
    assign cur_reg    = cur_idx;
    assign first_xfer = idle & instr;
    assign finished   = work_le_one | (idle & ~instr);
    assign pc_xfer    = mode.ldm & (cur_idx == 4'd15);
    assign empty_list = first_xfer & work_zero;

    always_ff @(posedge nGCLK or negedge nRESET) begin
        if (!nRESET) begin
            state_q  <= SEQ_IDLE;
            remain_q <= 16'd0;
            k_q      <= 4'd0;
            n_reg_q  <= 5'd0;
            mode_q   <= '0;
        end else if (nWAIT && squash) begin
            state_q  <= SEQ_IDLE;
            remain_q <= 16'd0;
            k_q      <= 4'd0;
            n_reg_q  <= 5'd0;
        end else if (advance) begin
            if (idle) begin
                if (instr && !work_le_one) begin
                    state_q  <= SEQ_XFER;
                    remain_q <= work_cleared;
                    k_q      <= 4'd1;
                    n_reg_q  <= live_n;
                    mode_q   <= mode;
                end
            end else if (work_le_one) begin
                state_q  <= SEQ_IDLE;
                remain_q <= 16'd0;
                k_q      <= 4'd0;
                n_reg_q  <= 5'd0;
            end else begin
                remain_q <= work_cleared;
                k_q      <= k_q + 4'd1;
            end
        end
    end

endmodule
